// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer
//   Walks a camera register table after start_i and issues one SCCB write per
//   entry. Table entries are {reg, val}: 16'hFFFF ends the table, reg 8'hFE
//   inserts a delay of val milliseconds, anything else is a register write.
//   NACKed writes are re-issued up to MAX_RETRY times. The video pipeline is
//   held off until cfg_done_o.
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i, abort_i      1-cycle control pulses (abort wins over start)
//   rom_addr_o/rom_data_i table read port, data valid 1 cycle after address
//   sccb_valid_o/ready_i  request handshake to the SCCB master
//   sccb_dev_o/reg_o/data_o  write payload (dev is the constant DEV_ADDR)
//   sccb_done_i/nack_i    transfer completion, nack qualified by done
//   cfg_busy_o/done_o/error_o, err_index_o  status
module cam_cfg_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned ROM_AW      = 8,
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              sccb_valid_o,
  input  logic              sccb_ready_i,
  output logic [7:0]        sccb_dev_o,
  output logic [7:0]        sccb_reg_o,
  output logic [7:0]        sccb_data_o,
  input  logic              sccb_done_i,
  input  logic              sccb_nack_i,
  output logic              cfg_busy_o,
  output logic              cfg_done_o,
  output logic              cfg_error_o,
  output logic [ROM_AW-1:0] err_index_o
);

  // Degenerate parameter values are clamped so every counter has at least one bit.
  localparam int unsigned TickCycles = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int unsigned TickW      = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int unsigned GapN       = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int unsigned GapW       = (GapN > 1) ? $clog2(GapN) : 1;
  localparam int unsigned RetryW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [ROM_AW-1:0] LastIdx = '1;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StReq    = 4'd3;
  localparam logic [3:0] StWait   = 4'd4;
  localparam logic [3:0] StGap    = 4'd5;
  localparam logic [3:0] StDelay  = 4'd6;
  localparam logic [3:0] StDone   = 4'd7;
  localparam logic [3:0] StError  = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [ROM_AW-1:0] index_q, index_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        ms_q, ms_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ROM_AW-1:0] err_idx_q, err_idx_d;

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    retry_d   = retry_q;
    reg_d     = reg_q;
    data_d    = data_q;
    ms_d      = ms_q;
    tick_d    = tick_q;
    gap_d     = gap_q;
    abort_d   = abort_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start_i && !abort_i) begin
          state_d   = StFetch;
          index_d   = '0;
          retry_d   = '0;
          abort_d   = 1'b0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      StFetch: begin
        state_d = abort_i ? StIdle : StDecode;
      end
      StDecode: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (rom_data_i == 16'hFFFF) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (rom_data_i[15:8] == 8'hFE) begin
          state_d = StDelay;
          ms_d    = rom_data_i[7:0];
          tick_d  = '0;
        end else begin
          state_d = StReq;
          reg_d   = rom_data_i[15:8];
          data_d  = rom_data_i[7:0];
        end
      end
      StReq: begin
        // A handshake coinciding with abort is still an accepted transfer.
        if (sccb_ready_i) begin
          state_d = StWait;
          abort_d = abort_i;
        end else if (abort_i) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (sccb_done_i) begin
          if (abort_q || abort_i) begin
            state_d = StIdle;
            abort_d = 1'b0;
          end else if (!sccb_nack_i) begin
            retry_d = '0;
            if (index_q == LastIdx) begin
              state_d   = StError;
              error_d   = 1'b1;
              err_idx_d = index_q;
            end else begin
              state_d = StGap;
              gap_d   = '0;
              index_d = index_q + 1'b1;
            end
          end else if (retry_q == RetryW'(MAX_RETRY)) begin
            state_d   = StError;
            error_d   = 1'b1;
            err_idx_d = index_q;
          end else begin
            // Same index: the entry is fetched and re-issued after the gap.
            state_d = StGap;
            gap_d   = '0;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (gap_q == GapW'(GapN - 1)) begin
          state_d = StFetch;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDelay: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (ms_q == 8'd0) begin
          if (index_q == LastIdx) begin
            state_d   = StError;
            error_d   = 1'b1;
            err_idx_d = index_q;
          end else begin
            state_d = StFetch;
            index_d = index_q + 1'b1;
          end
        end else if (tick_q == TickW'(TickCycles - 1)) begin
          tick_d = '0;
          ms_d   = ms_q - 8'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      index_q   <= '0;
      retry_q   <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      ms_q      <= '0;
      tick_q    <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      ms_q      <= ms_d;
      tick_q    <= tick_d;
      gap_q     <= gap_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign rom_addr_o   = index_q;
  assign sccb_valid_o = (state_q == StReq);
  assign sccb_dev_o   = DEV_ADDR;
  assign sccb_reg_o   = reg_q;
  assign sccb_data_o  = data_q;
  assign cfg_busy_o   = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
  assign cfg_done_o   = done_q;
  assign cfg_error_o  = error_q;
  assign err_index_o  = err_idx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: an 8-bit-address instance (a) for the main
// scenarios and a 2-bit-address instance (b) for table overrun. Table ROMs and
// SCCB masters are modelled on the falling edge.
module tb_cam_cfg_sequencer;

  localparam int DoneLat = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;

  logic [7:0]  rom_addr_a, dev_a, reg_a, data_a, eidx_a;
  logic [15:0] rom_data_a = 16'h0;
  logic        valid_a, busy_a, cdone_a, err_a;
  logic        ready_a = 1'b0, done_a = 1'b0, nack_a = 1'b0;

  logic [1:0]  rom_addr_b, eidx_b;
  logic [7:0]  dev_b, reg_b, data_b;
  logic [15:0] rom_data_b = 16'h0;
  logic        valid_b, busy_b, cdone_b, err_b;
  logic        ready_b = 1'b0, done_b = 1'b0, nack_b = 1'b0;

  cam_cfg_sequencer #(.CLK_FREQ_HZ(10_000), .ROM_AW(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .abort_i(abort_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .sccb_valid_o(valid_a), .sccb_ready_i(ready_a), .sccb_dev_o(dev_a),
    .sccb_reg_o(reg_a), .sccb_data_o(data_a), .sccb_done_i(done_a), .sccb_nack_i(nack_a),
    .cfg_busy_o(busy_a), .cfg_done_o(cdone_a), .cfg_error_o(err_a), .err_index_o(eidx_a)
  );

  cam_cfg_sequencer #(.CLK_FREQ_HZ(10_000), .ROM_AW(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .abort_i(abort_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .sccb_valid_o(valid_b), .sccb_ready_i(ready_b), .sccb_dev_o(dev_b),
    .sccb_reg_o(reg_b), .sccb_data_o(data_b), .sccb_done_i(done_b), .sccb_nack_i(nack_b),
    .cfg_busy_o(busy_b), .cfg_done_o(cdone_b), .cfg_error_o(err_b), .err_index_o(eidx_b)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [4];

  // Stimulus knobs (written by the initial block only)
  int ready_delay = 0;
  int nack_limit  = 0;

  // Master model a state (written by its always block only)
  int       hs_a = 0, unstable_a = 0, nack_given = 0, vcnt_a = 0, dcnt_a = 0;
  logic [7:0] first_reg, first_data;
  logic [7:0] log_reg [64];
  logic [7:0] log_data [64];
  int         log_cyc [64];
  int         log_hold [64];
  int         hs_b = 0, dcnt_b = 0;

  always @(negedge clk) begin
    rom_data_a = rom_a[rom_addr_a];
    done_a = 1'b0;
    nack_a = 1'b0;
    if (dcnt_a > 0) begin
      dcnt_a = dcnt_a - 1;
      if (dcnt_a == 0) begin
        done_a = 1'b1;
        if (nack_given < nack_limit) begin
          nack_a = 1'b1;
          nack_given = nack_given + 1;
        end
      end
    end
    if (valid_a) begin
      if (vcnt_a == 0) begin
        first_reg  = reg_a;
        first_data = data_a;
      end else if (reg_a !== first_reg || data_a !== first_data) begin
        unstable_a = unstable_a + 1;
      end
      if (vcnt_a >= ready_delay) begin
        ready_a = 1'b1;
        log_reg[hs_a]  = reg_a;
        log_data[hs_a] = data_a;
        log_cyc[hs_a]  = cyc;
        log_hold[hs_a] = vcnt_a;
        hs_a   = hs_a + 1;
        dcnt_a = DoneLat;
        vcnt_a = 0;
      end else begin
        ready_a = 1'b0;
        vcnt_a  = vcnt_a + 1;
      end
    end else begin
      ready_a = 1'b0;
      vcnt_a  = 0;
    end
  end

  always @(negedge clk) begin
    rom_data_b = rom_b[rom_addr_b];
    done_b = 1'b0;
    if (dcnt_b > 0) begin
      dcnt_b = dcnt_b - 1;
      if (dcnt_b == 0) done_b = 1'b1;
    end
    ready_b = valid_b;
    if (valid_b) begin
      hs_b   = hs_b + 1;
      dcnt_b = DoneLat;
    end
  end

  task automatic load_std();
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
    rom_a[0] = 16'h1280;
    rom_a[1] = 16'hFE0A;
    rom_a[2] = 16'h1101;
    rom_a[3] = 16'hFFFF;
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, output bit timed_out);
    int n = 0;
    while (busy_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    timed_out = busy_a;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", valid_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
    tests++; if (cdone_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL reset_status: got done=%b err=%b, expected 0 0", cdone_a, err_a); end
    tests++; if (rom_addr_a !== 8'h00 || eidx_a !== 8'h00) begin fails++; $display("FAIL reset_addr: got addr=%h eidx=%h, expected 00 00", rom_addr_a, eidx_a); end
    tests++; if (reg_a !== 8'h00 || data_a !== 8'h00) begin fails++; $display("FAIL reset_payload: got %h/%h, expected 00/00", reg_a, data_a); end
    tests++; if (busy_b !== 1'b0 || valid_b !== 1'b0) begin fails++; $display("FAIL reset_b: got busy=%b valid=%b, expected 0 0", busy_b, valid_b); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int b = hs_a;
    bit to;
    load_std();
    ready_delay = 0;
    nack_limit  = nack_given;
    pulse_start_a();
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL seq_busy: got %b, expected 1", busy_a); end
    wait_idle_a(3000, to);
    tests++; if (to) begin fails++; $display("FAIL seq_timeout: got busy, expected idle"); end
    tests++; if (hs_a - b !== 2) begin fails++; $display("FAIL seq_count: got %0d, expected 2", hs_a - b); end
    tests++; if (log_reg[b] !== 8'h12 || log_data[b] !== 8'h80) begin fails++; $display("FAIL seq_w0: got %h/%h, expected 12/80", log_reg[b], log_data[b]); end
    tests++; if (log_reg[b+1] !== 8'h11 || log_data[b+1] !== 8'h01) begin fails++; $display("FAIL seq_w1: got %h/%h, expected 11/01", log_reg[b+1], log_data[b+1]); end
    tests++; if (log_cyc[b+1] - log_cyc[b] < 100) begin fails++; $display("FAIL seq_gap: got %0d, expected >=100", log_cyc[b+1] - log_cyc[b]); end
    tests++; if (cdone_a !== 1'b1 || err_a !== 1'b0) begin fails++; $display("FAIL seq_status: got done=%b err=%b, expected 1 0", cdone_a, err_a); end
    tests++; if (dev_a !== 8'h42) begin fails++; $display("FAIL seq_dev: got %h, expected 42", dev_a); end
  endtask

  task automatic test_ready_hold();
    int b = hs_a;
    int u = unstable_a;
    bit to;
    load_std();
    ready_delay = 7;
    pulse_start_a();
    wait_idle_a(3000, to);
    tests++; if (to) begin fails++; $display("FAIL hold_timeout: got busy, expected idle"); end
    tests++; if (hs_a - b !== 2) begin fails++; $display("FAIL hold_count: got %0d, expected 2", hs_a - b); end
    tests++; if (log_hold[b] !== 7) begin fails++; $display("FAIL hold_cycles: got %0d, expected 7", log_hold[b]); end
    tests++; if (unstable_a - u !== 0) begin fails++; $display("FAIL hold_stable: got %0d changes, expected 0", unstable_a - u); end
    tests++; if (log_reg[b] !== 8'h12 || log_data[b] !== 8'h80) begin fails++; $display("FAIL hold_w0: got %h/%h, expected 12/80", log_reg[b], log_data[b]); end
    tests++; if (cdone_a !== 1'b1) begin fails++; $display("FAIL hold_done: got %b, expected 1", cdone_a); end
  endtask

  task automatic test_async_reset();
    int b = hs_a;
    int n = 0;
    load_std();
    ready_delay = 7;
    pulse_start_a();
    while (!valid_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL arst_req: got valid=%b, expected 1", valid_a); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL arst_idle: got valid=%b busy=%b, expected 0 0", valid_a, busy_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (hs_a - b !== 0) begin fails++; $display("FAIL arst_nohs: got %0d, expected 0", hs_a - b); end
    ready_delay = 0;
  endtask

  task automatic test_nack_exhaust();
    int b = hs_a;
    bit to;
    load_std();
    ready_delay = 0;
    nack_limit  = nack_given + 1000;
    pulse_start_a();
    wait_idle_a(3000, to);
    nack_limit = nack_given;
    tests++; if (to) begin fails++; $display("FAIL nack3_timeout: got busy, expected idle"); end
    tests++; if (hs_a - b !== 4) begin fails++; $display("FAIL nack3_count: got %0d, expected 4", hs_a - b); end
    tests++; if (err_a !== 1'b1 || cdone_a !== 1'b0) begin fails++; $display("FAIL nack3_status: got err=%b done=%b, expected 1 0", err_a, cdone_a); end
    tests++; if (eidx_a !== 8'h00) begin fails++; $display("FAIL nack3_eidx: got %h, expected 00", eidx_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL nack3_busy: got %b, expected 0", busy_a); end
  endtask

  task automatic test_nack_retry();
    int b = hs_a;
    bit to;
    load_std();
    ready_delay = 0;
    nack_limit  = nack_given + 1;
    pulse_start_a();
    wait_idle_a(3000, to);
    tests++; if (to) begin fails++; $display("FAIL nack1_timeout: got busy, expected idle"); end
    tests++; if (hs_a - b !== 3) begin fails++; $display("FAIL nack1_count: got %0d, expected 3", hs_a - b); end
    tests++; if (log_reg[b] !== 8'h12 || log_reg[b+1] !== 8'h12 || log_reg[b+2] !== 8'h11) begin
      fails++; $display("FAIL nack1_order: got %h %h %h, expected 12 12 11", log_reg[b], log_reg[b+1], log_reg[b+2]);
    end
    tests++; if (cdone_a !== 1'b1 || err_a !== 1'b0) begin fails++; $display("FAIL nack1_status: got done=%b err=%b, expected 1 0", cdone_a, err_a); end
  endtask

  task automatic test_abort();
    int b = hs_a;
    int n = 0;
    bit to;
    load_std();
    ready_delay = 0;
    nack_limit  = nack_given;
    pulse_start_a();
    while (hs_a == b && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++; if (hs_a - b !== 1) begin fails++; $display("FAIL abort_hs: got %0d, expected 1", hs_a - b); end
    repeat (3) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL abort_hold: got busy=%b, expected 1", busy_a); end
    wait_idle_a(200, to);
    tests++; if (to) begin fails++; $display("FAIL abort_timeout: got busy, expected idle"); end
    repeat (40) @(negedge clk);
    tests++; if (hs_a - b !== 1) begin fails++; $display("FAIL abort_noreq: got %0d, expected 1", hs_a - b); end
    tests++; if (cdone_a !== 1'b0 || err_a !== 1'b0) begin fails++; $display("FAIL abort_status: got done=%b err=%b, expected 0 0", cdone_a, err_a); end
    // start and abort together: abort wins, stays idle
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_wins: got busy=%b, expected 0", busy_a); end
    b = hs_a;
    pulse_start_a();
    wait_idle_a(3000, to);
    tests++; if (hs_a - b !== 2 || log_reg[b] !== 8'h12) begin fails++; $display("FAIL abort_restart: got %0d writes first reg %h, expected 2 12", hs_a - b, log_reg[b]); end
    tests++; if (cdone_a !== 1'b1) begin fails++; $display("FAIL abort_redone: got %b, expected 1", cdone_a); end
  endtask

  task automatic test_overrun();
    int b = hs_b;
    int n = 0;
    rom_b[0] = 16'h1001;
    rom_b[1] = 16'h1102;
    rom_b[2] = 16'h1203;
    rom_b[3] = 16'h1304;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (busy_b && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL ovr_timeout: got busy, expected idle"); end
    tests++; if (hs_b - b !== 4) begin fails++; $display("FAIL ovr_count: got %0d, expected 4", hs_b - b); end
    tests++; if (err_b !== 1'b1 || cdone_b !== 1'b0) begin fails++; $display("FAIL ovr_status: got err=%b done=%b, expected 1 0", err_b, cdone_b); end
    tests++; if (eidx_b !== 2'd3) begin fails++; $display("FAIL ovr_eidx: got %0d, expected 3", eidx_b); end
  endtask

  initial begin
    load_std();
    for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;
    test_reset();
    test_sequence();
    test_ready_hold();
    test_async_reset();
    test_nack_exhaust();
    test_nack_retry();
    test_abort();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
